// File: rtl/serializador_if.sv
// Parallel-in / serial-out link bundle for serializador.
// Upstream offers words on in_*; the serial line comes back on data/DK_out/frame_start/idle_sent.
interface serializador_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_DK;
    logic             data;
    logic             DK_out;
    logic             frame_start;
    logic             idle_sent;

    // master: upstream word source and line observer
    modport master (
        output in_valid, in_data, in_DK,
        input  in_ready, data, DK_out, frame_start, idle_sent
    );

    // slave: the serializer itself
    modport slave (
        input  in_valid, in_data, in_DK,
        output in_ready, data, DK_out, frame_start, idle_sent
    );
endinterface

// File: rtl/serializador.sv
// Parallel-to-serial transmit stage, MSB first, one WIDTH-bit slot per WIDTH clocks.
// Ports: clk, reset (sync, active-high), bus (slave: in_valid/in_ready/in_data/in_DK in,
//        data/DK_out/frame_start/idle_sent out). Empty slots carry IDLE_CHAR with DK_out=1.
module serializador #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_CHAR = 8'hBC
) (
    input logic           clk,
    input logic           reset,
    serializador_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        LOAD,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             dk_q;
    logic             idle_q;
    logic             ready;

    // Slot boundary: the single LOAD cycle after reset, or the last bit of a slot.
    assign ready = (state == LOAD) || ((state == SHIFT) && (cnt == LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOAD;
            cnt    <= '0;
            shreg  <= '0;
            dk_q   <= 1'b0;
            idle_q <= 1'b0;
        end else if (ready) begin
            state <= SHIFT;
            cnt   <= '0;
            if (bus.in_valid) begin
                shreg  <= bus.in_data;
                dk_q   <= bus.in_DK;
                idle_q <= 1'b0;
            end else begin
                // no offer: keep the line busy with the comma fill
                shreg  <= IDLE_CHAR;
                dk_q   <= 1'b1;
                idle_q <= 1'b1;
            end
        end else begin
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.data        = shreg[WIDTH-1];
    assign bus.DK_out      = dk_q;
    assign bus.idle_sent   = idle_q;
    assign bus.frame_start = (state == SHIFT) && (cnt == '0);
endmodule

// File: tb/tb_serializador.sv
// Directed and random-mix bench for serializador with a deserializer loopback model.
// Inputs change #1 after posedge; outputs are sampled at that point or at the posedge itself.
module tb_serializador;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_words = 0;

    typedef struct packed {
        logic       dk;
        logic       idle;
        logic [7:0] d;
    } word_t;

    word_t q[$];

    serializador_if #(.WIDTH(8)) bus ();

    serializador #(
        .WIDTH    (8),
        .IDLE_CHAR(8'hBC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes the current cycle is a slot boundary with the offer already driven.
    task automatic send_word(input logic [7:0] w, input logic dk, input logic idle);
        tick();
        bus.in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("bit", bus.data, w[7-j]);
            check("dk", bus.DK_out, dk);
            check("idle", bus.idle_sent, idle);
            check("fs", bus.frame_start, j == 0);
            check("rdy", bus.in_ready, j == 7);
            if (j < 7) tick();
        end
    endtask

    // Reference: slot timing model, scoreboard and a deserializer rebuilding out[7-counter].
    initial begin
        logic       m_ld;
        int         m_ph;
        int         d_idx;
        logic [7:0] d_word;
        word_t      e;
        m_ld   = 1'b1;
        m_ph   = 0;
        d_idx  = -1;
        d_word = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                m_ld  = 1'b1;
                d_idx = -1;
            end else begin
                if (bus.frame_start) d_idx = 0;
                if (d_idx >= 0) begin
                    if (q.size() == 0) begin
                        check("q_empty", 1, 0);
                        d_idx = -1;
                    end else begin
                        d_word[7-d_idx] = bus.data;
                        check("slot_dk", bus.DK_out, q[0].dk);
                        check("slot_idle", bus.idle_sent, q[0].idle);
                        if (d_idx == 7) begin
                            check("loop_data", d_word, q[0].d);
                            void'(q.pop_front());
                            n_words++;
                            d_idx = -1;
                        end else begin
                            d_idx++;
                        end
                    end
                end
                check("rdy_model", bus.in_ready, m_ld);
                if (m_ld) begin
                    if (bus.in_valid) e = '{dk: bus.in_DK, idle: 1'b0, d: bus.in_data};
                    else e = '{dk: 1'b1, idle: 1'b1, d: 8'hBC};
                    q.push_back(e);
                    m_ph = 0;
                    m_ld = 1'b0;
                end else begin
                    m_ph++;
                    if (m_ph == 7) m_ld = 1'b1;
                end
            end
        end
    end

    initial begin
        logic       v;
        logic       drop;
        int         st;
        logic [7:0] rd;
        logic       rk;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_DK    = 1'b0;

        // 1: reset then idle fill
        repeat (3) tick();
        reset = 1'b0;
        check("rst_rdy", bus.in_ready, 1);
        check("rst_data", bus.data, 0);
        check("rst_dk", bus.DK_out, 0);
        check("rst_idle", bus.idle_sent, 0);
        check("rst_fs", bus.frame_start, 0);
        send_word(8'hBC, 1'b1, 1'b1);

        // 2: single data word
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.in_DK    = 1'b0;
        send_word(8'hA5, 1'b0, 1'b0);

        // 3: back-to-back words
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_DK    = 1'b0;
        send_word(8'h00, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_DK    = 1'b0;
        send_word(8'hFF, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h1C;
        bus.in_DK    = 1'b1;
        send_word(8'h1C, 1'b1, 1'b0);

        // 4: offer raised mid-slot at cnt=3, held until the boundary
        tick();
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        bus.in_DK    = 1'b0;
        for (int k = 3; k < 7; k++) begin
            check("early_rdy", bus.in_ready, 0);
            check("early_idle", bus.idle_sent, 1);
            tick();
        end
        check("late_rdy", bus.in_ready, 1);
        send_word(8'h3C, 1'b0, 1'b0);

        // 5: reset mid-slot, then reset on an accept edge
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.in_DK    = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        check("mid_cnt4_bit", bus.data, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_data", bus.data, 0);
        check("mid_rst_rdy", bus.in_ready, 1);
        check("mid_rst_dk", bus.DK_out, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        bus.in_DK    = 1'b1;
        tick();
        reset = 1'b0;
        check("acc_rst_data", bus.data, 0);
        check("acc_rst_fs", bus.frame_start, 0);
        check("acc_rst_rdy", bus.in_ready, 1);
        send_word(8'h5A, 1'b1, 1'b0);

        // 6: random valid/idle mix with occasional withdrawn offers
        tick();
        for (int s = 0; s < 1000; s++) begin
            v    = ($urandom_range(0, 3) != 0);
            st   = $urandom_range(0, 7);
            drop = (st < 6) && ($urandom_range(0, 9) == 0);
            rd   = 8'($urandom);
            rk   = 1'($urandom);
            for (int k = 0; k < 8; k++) begin
                if (v && k == st) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = rd;
                    bus.in_DK    = rk;
                end
                if (v && drop && k == st + 1) bus.in_valid = 1'b0;
                tick();
                if (k == 7) bus.in_valid = 1'b0;
            end
        end
        repeat (9) tick();
        check("words_seen", n_words >= 1000, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
